// File: rtl/rv32i_pkg.sv
// Shared decode types for the RV32I pipeline: per-slot control word, issue slot record
// and the small classification helpers the issue unit uses.
package rv32i_pkg;

  localparam int REG_IDX_W = 5;

  typedef struct packed {
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic branch;
    logic jump;
    logic system;
    logic lui;
    logic auipc;
  } control_t;

  typedef struct packed {
    logic                 valid;
    control_t             ctrl;
    logic [REG_IDX_W-1:0] rs1;
    logic [REG_IDX_W-1:0] rs2;
    logic [REG_IDX_W-1:0] rd;
    logic                 use_rs1;
    logic                 use_rs2;
  } issue_slot_t;

  function automatic logic is_mem(input control_t c);
    return c.mem_read | c.mem_write;
  endfunction

  // Control transfers and system ops close the issue group behind them.
  function automatic logic ends_group(input control_t c);
    return c.branch | c.jump | c.system;
  endfunction

endpackage

// File: rtl/issue_sb_nw_if.sv
// Decode-to-issue bundle: ISSUE_W decoded slots in, issue decision out.
interface issue_sb_nw_if #(
    parameter int ISSUE_W = 2
) ();
    import rv32i_pkg::*;

    localparam int CNT_W = $clog2(ISSUE_W + 1);

    // Slot k transfers on a cycle where slot_valid[k] && issue_mask[k]; slots that did not
    // issue are held by decode and re-presented (shifted toward slot 0) on a later cycle.
    logic [ISSUE_W-1:0]                slot_valid;
    control_t [ISSUE_W-1:0]            slot_ctrl;
    logic [ISSUE_W-1:0][REG_IDX_W-1:0] slot_rs1;
    logic [ISSUE_W-1:0][REG_IDX_W-1:0] slot_rs2;
    logic [ISSUE_W-1:0][REG_IDX_W-1:0] slot_rd;
    logic [ISSUE_W-1:0]                slot_use_rs1;
    logic [ISSUE_W-1:0]                slot_use_rs2;
    logic [ISSUE_W-1:0]                issue_mask;
    logic [CNT_W-1:0]                  issue_count;
    logic                              stall_if;

    modport master (
        output slot_valid, slot_ctrl, slot_rs1, slot_rs2, slot_rd, slot_use_rs1, slot_use_rs2,
        input  issue_mask, issue_count, stall_if
    );

    modport slave (
        input  slot_valid, slot_ctrl, slot_rs1, slot_rs2, slot_rd, slot_use_rs1, slot_use_rs2,
        output issue_mask, issue_count, stall_if
    );

endinterface

// File: rtl/sb_reg_timer.sv
// One scoreboard entry: latency countdown plus load flag for a single register.
// With ISSUE_SB_LOAD_WB_EN, load entries hold until an explicit writeback strobe.
module sb_reg_timer #(
    parameter int ALU_LAT  = 1,
    parameter int LOAD_LAT = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic set_i,
    input  logic set_ld_i,
`ifdef ISSUE_SB_LOAD_WB_EN
    input  logic wb_i,
`endif
    output logic busy_o,
    output logic ld_pend_o
);
    localparam int TW = $clog2(LOAD_LAT + 1);

    logic [TW-1:0] timer_q, timer_d;
    logic          ld_q, ld_d;

    always_comb begin
        timer_d = timer_q;
        ld_d    = ld_q;
        if (clr_i) begin
            timer_d = '0;
            ld_d    = 1'b0;
        end else if (set_i) begin
            timer_d = set_ld_i ? TW'(LOAD_LAT) : TW'(ALU_LAT);
            ld_d    = set_ld_i;
`ifdef ISSUE_SB_LOAD_WB_EN
        end else if (ld_q) begin
            if (wb_i) begin
                timer_d = '0;
                ld_d    = 1'b0;
            end
        end else if (timer_q != '0) begin
            timer_d = timer_q - TW'(1);
`else
        end else if (timer_q != '0) begin
            timer_d = timer_q - TW'(1);
            if (timer_q == TW'(1)) ld_d = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer_q <= '0;
            ld_q    <= 1'b0;
        end else begin
            timer_q <= timer_d;
            ld_q    <= ld_d;
        end
    end

    assign busy_o    = (timer_q != '0);
    assign ld_pend_o = busy_o && ld_q;

endmodule

// File: rtl/issue_sb_nw.sv
// N-wide in-order issue unit with a per-register latency scoreboard.
// Optional ISSUE_SB_LOAD_WB_EN: loads stay busy until ld_wb_valid/ld_wb_rd retires them.
module issue_sb_nw
    import rv32i_pkg::*;
#(
    parameter int ISSUE_W     = 2,
    parameter int NUM_REGS    = 32,
    parameter int ALU_LAT     = 1,
    parameter int LOAD_LAT    = 2,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    issue_sb_nw_if.slave           id_if,
`ifdef ISSUE_SB_LOAD_WB_EN
    input  logic                   ld_wb_valid,
    input  logic [REG_IDX_W-1:0]   ld_wb_rd,
`endif
    output logic [NUM_REGS-1:0]    busy_vec,
    output logic [NUM_REGS-1:0]    load_pending_vec,
    output logic [STALL_CNT_W-1:0] stall_cycles
);
    localparam int CNT_W = $clog2(ISSUE_W + 1);

    issue_slot_t        slot [ISSUE_W];
    logic [ISSUE_W-1:0] wr, s1v, s2v, issue;
    logic [CNT_W-1:0]   cnt;
    logic               stall;
    logic [STALL_CNT_W-1:0] stall_q;

    always_comb begin
        for (int k = 0; k < ISSUE_W; k++) begin
            slot[k].valid   = id_if.slot_valid[k];
            slot[k].ctrl    = id_if.slot_ctrl[k];
            slot[k].rs1     = id_if.slot_rs1[k];
            slot[k].rs2     = id_if.slot_rs2[k];
            slot[k].rd      = id_if.slot_rd[k];
            slot[k].use_rs1 = id_if.slot_use_rs1[k];
            slot[k].use_rs2 = id_if.slot_use_rs2[k];
            wr[k]  = slot[k].ctrl.reg_write && (slot[k].rd != '0);
            s1v[k] = slot[k].use_rs1 && (slot[k].rs1 != '0);
            s2v[k] = slot[k].use_rs2 && (slot[k].rs2 != '0);
        end
    end

    // Slot 0 only waits on loads (ALU results forward); younger slots must be fully
    // independent of the scoreboard and of every older slot in the group.
    always_comb begin
        logic prefix_ok, term, mem_seen, hazard;
        issue     = '0;
        prefix_ok = 1'b1;
        term      = 1'b0;
        mem_seen  = 1'b0;
        for (int k = 0; k < ISSUE_W; k++) begin
            if (k == 0) begin
                hazard = (s1v[0] && load_pending_vec[slot[0].rs1]) ||
                         (s2v[0] && load_pending_vec[slot[0].rs2]);
            end else begin
                hazard = (s1v[k] && busy_vec[slot[k].rs1]) ||
                         (s2v[k] && busy_vec[slot[k].rs2]) ||
                         (is_mem(slot[k].ctrl) && mem_seen) ||
                         ((slot[k].ctrl.lui || slot[k].ctrl.auipc) && wr[k]);
                for (int j = 0; j < k; j++) begin
                    hazard = hazard ||
                        (wr[j] && s1v[k] && slot[k].rs1 == slot[j].rd) ||
                        (wr[j] && s2v[k] && slot[k].rs2 == slot[j].rd) ||
                        (wr[j] && wr[k] && slot[k].rd == slot[j].rd) ||
                        (wr[k] && s1v[j] && slot[j].rs1 == slot[k].rd) ||
                        (wr[k] && s2v[j] && slot[j].rs2 == slot[k].rd);
                end
                if (slot[k].ctrl.system) hazard = 1'b0;
            end
            issue[k]  = slot[k].valid && prefix_ok && !term && !flush && !hazard;
            prefix_ok = issue[k];
            term      = term || ends_group(slot[k].ctrl);
            mem_seen  = mem_seen || is_mem(slot[k].ctrl);
        end
    end

    always_comb begin
        cnt = '0;
        for (int k = 0; k < ISSUE_W; k++) cnt = cnt + CNT_W'(issue[k]);
    end

    assign stall             = id_if.slot_valid[0] && !issue[0] && !flush;
    assign id_if.issue_mask  = issue;
    assign id_if.issue_count = cnt;
    assign id_if.stall_if    = stall;

    assign busy_vec[0]         = 1'b0;
    assign load_pending_vec[0] = 1'b0;

    for (genvar r = 1; r < NUM_REGS; r++) begin : g_reg
        logic set_r, ld_r;
        always_comb begin
            set_r = 1'b0;
            ld_r  = 1'b0;
            for (int k = 0; k < ISSUE_W; k++) begin
                if (issue[k] && wr[k] && slot[k].rd == REG_IDX_W'(r)) begin
                    set_r = 1'b1;
                    ld_r  = slot[k].ctrl.mem_read;
                end
            end
        end

        sb_reg_timer #(
            .ALU_LAT  (ALU_LAT),
            .LOAD_LAT (LOAD_LAT)
        ) u_timer (
            .clk       (clk),
            .rst_n     (rst_n),
            .clr_i     (flush),
            .set_i     (set_r),
            .set_ld_i  (ld_r),
`ifdef ISSUE_SB_LOAD_WB_EN
            .wb_i      (ld_wb_valid && ld_wb_rd == REG_IDX_W'(r)),
`endif
            .busy_o    (busy_vec[r]),
            .ld_pend_o (load_pending_vec[r])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) stall_q <= '0;
        else if (stall && stall_q != '1) stall_q <= stall_q + STALL_CNT_W'(1);
    end

    assign stall_cycles = stall_q;

endmodule

// File: tb/tb_issue_sb_nw.sv
// Bench for issue_sb_nw (4-wide): vector table, hand-written multi-cycle sequences and
// random traffic, all scored against a behavioural scoreboard model.
module tb_issue_sb_nw;
  import rv32i_pkg::*;

  localparam int W   = 4;
  localparam int NR  = 32;
  localparam int ALU = 1;
  localparam int LD  = 2;
  localparam int SCW = 16;

  localparam int OP_NOP = 0, OP_ADD = 1, OP_LW = 2, OP_SW = 3, OP_BEQ = 4, OP_LUI = 5, OP_ECALL = 6;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  logic [NR-1:0]  busy_vec, load_pending_vec;
  logic [SCW-1:0] stall_cycles;
`ifdef ISSUE_SB_LOAD_WB_EN
  logic       ld_wb_valid = 1'b0;
  logic [4:0] ld_wb_rd = '0;
`endif

  issue_sb_nw_if #(.ISSUE_W(W)) id_if ();

  issue_sb_nw #(
    .ISSUE_W(W), .NUM_REGS(NR), .ALU_LAT(ALU), .LOAD_LAT(LD), .STALL_CNT_W(SCW)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .flush            (flush),
    .id_if            (id_if),
`ifdef ISSUE_SB_LOAD_WB_EN
    .ld_wb_valid      (ld_wb_valid),
    .ld_wb_rd         (ld_wb_rd),
`endif
    .busy_vec         (busy_vec),
    .load_pending_vec (load_pending_vec),
    .stall_cycles     (stall_cycles)
  );

  always #5 clk = ~clk;

  // ---------------- bookkeeping ----------------
  int n_pass = 0;
  int n_checks = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  // ---------------- stimulus helpers ----------------
  issue_slot_t sl [W];

  function automatic issue_slot_t op(input int kind, input int rd, input int rs1, input int rs2);
    issue_slot_t s;
    s = '0;
    s.valid = (kind != OP_NOP);
    s.rd  = 5'(rd);
    s.rs1 = 5'(rs1);
    s.rs2 = 5'(rs2);
    case (kind)
      OP_ADD:   begin s.ctrl.reg_write = 1; s.use_rs1 = 1; s.use_rs2 = 1; end
      OP_LW:    begin s.ctrl.reg_write = 1; s.ctrl.mem_read = 1; s.use_rs1 = 1; end
      OP_SW:    begin s.ctrl.mem_write = 1; s.use_rs1 = 1; s.use_rs2 = 1; end
      OP_BEQ:   begin s.ctrl.branch = 1; s.use_rs1 = 1; s.use_rs2 = 1; end
      OP_LUI:   begin s.ctrl.reg_write = 1; s.ctrl.lui = 1; end
      OP_ECALL: begin s.ctrl.system = 1; end
      default:  s = '0;
    endcase
    return s;
  endfunction

  task automatic clear_slots();
    for (int k = 0; k < W; k++) sl[k] = '0;
  endtask

  task automatic put_slots();
    for (int k = 0; k < W; k++) begin
      id_if.slot_valid[k]   = sl[k].valid;
      id_if.slot_ctrl[k]    = sl[k].ctrl;
      id_if.slot_rs1[k]     = sl[k].rs1;
      id_if.slot_rs2[k]     = sl[k].rs2;
      id_if.slot_rd[k]      = sl[k].rd;
      id_if.slot_use_rs1[k] = sl[k].use_rs1;
      id_if.slot_use_rs2[k] = sl[k].use_rs2;
    end
  endtask

  // ---------------- behavioural model ----------------
  // Remaining busy cycles and load-ness per architectural register.
  int mt [NR];
  bit mf [NR];
  int m_stall;

  function automatic int dest(input issue_slot_t s);
    return s.ctrl.reg_write ? int'(s.rd) : 0;
  endfunction

  function automatic bit reads(input issue_slot_t s, input int r);
    return r != 0 && ((s.use_rs1 && int'(s.rs1) == r) || (s.use_rs2 && int'(s.rs2) == r));
  endfunction

  function automatic bit reads_busy(input issue_slot_t s, input bit loads_only);
    for (int r = 1; r < NR; r++)
      if (reads(s, r) && mt[r] > 0 && (!loads_only || mf[r])) return 1;
    return 0;
  endfunction

  function automatic logic [W-1:0] model_issue();
    logic [W-1:0] m;
    bit closed, mem_used, blocked;
    m = '0;
    closed = 0;
    mem_used = 0;
    if (flush) return m;
    for (int k = 0; k < W; k++) begin
      if (!sl[k].valid || closed) break;
      if (k == 0) begin
        if (reads_busy(sl[0], 1)) break;
      end else if (!sl[k].ctrl.system) begin
        blocked = reads_busy(sl[k], 0)
               || ((sl[k].ctrl.mem_read || sl[k].ctrl.mem_write) && mem_used)
               || ((sl[k].ctrl.lui || sl[k].ctrl.auipc) && dest(sl[k]) != 0);
        for (int j = 0; j < k; j++) begin
          if (reads(sl[k], dest(sl[j]))) blocked = 1;
          if (dest(sl[k]) != 0 && dest(sl[k]) == dest(sl[j])) blocked = 1;
          if (reads(sl[j], dest(sl[k]))) blocked = 1;
        end
        if (blocked) break;
      end
      m[k] = 1;
      closed = sl[k].ctrl.branch || sl[k].ctrl.jump || sl[k].ctrl.system;
      mem_used = mem_used || sl[k].ctrl.mem_read || sl[k].ctrl.mem_write;
    end
    return m;
  endfunction

  function automatic logic [NR-1:0] model_busy(input bit loads_only);
    logic [NR-1:0] v;
    v = '0;
    for (int r = 1; r < NR; r++) v[r] = mt[r] > 0 && (!loads_only || mf[r]);
    return v;
  endfunction

  task automatic model_reset();
    for (int r = 0; r < NR; r++) begin mt[r] = 0; mf[r] = 0; end
    m_stall = 0;
  endtask

  task automatic model_edge(input logic [W-1:0] m);
    if (sl[0].valid && !m[0] && !flush && m_stall < (1 << SCW) - 1) m_stall++;
    if (flush) begin
      for (int r = 0; r < NR; r++) begin mt[r] = 0; mf[r] = 0; end
      return;
    end
    for (int r = 1; r < NR; r++) begin
      if (mt[r] == 0) continue;
`ifdef ISSUE_SB_LOAD_WB_EN
      if (mf[r]) begin
        if (ld_wb_valid && int'(ld_wb_rd) == r) begin mt[r] = 0; mf[r] = 0; end
        continue;
      end
`endif
      mt[r]--;
      if (mt[r] == 0) mf[r] = 0;
    end
    for (int k = 0; k < W; k++) begin
      if (m[k] && dest(sl[k]) != 0) begin
        mt[dest(sl[k])] = sl[k].ctrl.mem_read ? LD : ALU;
        mf[dest(sl[k])] = sl[k].ctrl.mem_read;
      end
    end
  endtask

  // ---------------- one checked cycle ----------------
  logic [W-1:0]   s_mask;
  logic           s_stall;
  logic [NR-1:0]  s_busy;
  logic [SCW-1:0] s_cnt;

  task automatic step(input string nm);
    logic [W-1:0] em;
    put_slots();
    @(negedge clk);
    em = model_issue();
    s_mask  = id_if.issue_mask;
    s_stall = id_if.stall_if;
    s_busy  = busy_vec;
    s_cnt   = stall_cycles;
    chk({nm, ".mask"}, 64'(s_mask), 64'(em));
    chk({nm, ".count"}, 64'(id_if.issue_count), 64'($countones(em)));
    chk({nm, ".stall_if"}, 64'(s_stall), 64'(sl[0].valid && !em[0] && !flush));
    chk({nm, ".busy"}, 64'(s_busy), 64'(model_busy(0)));
    chk({nm, ".ldpend"}, 64'(load_pending_vec), 64'(model_busy(1)));
    chk({nm, ".stall_cnt"}, 64'(s_cnt), 64'(m_stall));
    @(posedge clk);
    model_edge(em);
    #1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    issue_slot_t  s [W];
    logic [W-1:0] exp;
  } vec_t;

  localparam int NV = 12;
  vec_t tbl [NV];

  task automatic set_vec(input int i, input issue_slot_t a, input issue_slot_t b,
                         input issue_slot_t c, input issue_slot_t d, input logic [W-1:0] e);
    tbl[i].s[0] = a; tbl[i].s[1] = b; tbl[i].s[2] = c; tbl[i].s[3] = d;
    tbl[i].exp = e;
  endtask

  initial begin
    #200000;
    n_checks++;
    $display("FAIL timeout: bench did not complete within time budget");
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    logic [SCW-1:0] base;
    issue_slot_t nop;
    nop = op(OP_NOP, 0, 0, 0);

    set_vec(0,  op(OP_ADD,1,0,0), op(OP_ADD,2,0,0), nop, nop, 4'b0011);
    set_vec(1,  op(OP_ADD,3,1,2), op(OP_ADD,4,3,1), nop, nop, 4'b0001);
    set_vec(2,  op(OP_BEQ,0,1,2), op(OP_ADD,1,0,0), op(OP_ADD,2,0,0), op(OP_ADD,3,0,0), 4'b0001);
    set_vec(3,  op(OP_LW,5,1,0), op(OP_ADD,6,0,0), op(OP_SW,0,1,2), nop, 4'b0011);
    set_vec(4,  op(OP_ADD,1,0,0), op(OP_LUI,2,0,0), nop, nop, 4'b0001);
    set_vec(5,  op(OP_ADD,1,0,0), op(OP_ADD,1,0,0), nop, nop, 4'b0001);
    set_vec(6,  op(OP_ADD,1,2,0), op(OP_ADD,2,0,0), nop, nop, 4'b0001);
    set_vec(7,  op(OP_ADD,1,0,0), op(OP_ADD,2,0,0), op(OP_ECALL,0,0,0), op(OP_ADD,3,0,0), 4'b0111);
    set_vec(8,  op(OP_ADD,1,0,0), op(OP_ADD,2,0,0), op(OP_ADD,3,0,0), op(OP_ADD,4,0,0), 4'b1111);
    set_vec(9,  nop, op(OP_ADD,1,0,0), nop, nop, 4'b0000);
    set_vec(10, op(OP_ADD,0,1,2), op(OP_ADD,0,3,4), nop, nop, 4'b0011);
    set_vec(11, op(OP_SW,0,1,2), op(OP_LW,3,0,0), nop, nop, 4'b0001);

    // clock/reset
    model_reset();
    clear_slots();
    put_slots();
    #3;
    chk("reset.busy", 64'(busy_vec), 64'(0));
    chk("reset.ldpend", 64'(load_pending_vec), 64'(0));
    chk("reset.stall_cnt", 64'(stall_cycles), 64'(0));
    chk("reset.mask", 64'(id_if.issue_mask), 64'(0));
    #9 rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < NV; i++) begin
      for (int k = 0; k < W; k++) sl[k] = tbl[i].s[k];
      step($sformatf("vec%0d", i));
      chk($sformatf("vec%0d.table_mask", i), 64'(s_mask), 64'(tbl[i].exp));
      clear_slots();
      flush = 1'b1;
      step("vec_flush");
      flush = 1'b0;
    end

    // two independent ALU writers: visible at t+1, clear at t+2
    sl[0] = op(OP_ADD,1,0,0); sl[1] = op(OP_ADD,2,0,0);
    step("lat_issue");
    chk("lat.mask", 64'(s_mask), 64'(4'b0011));
    clear_slots();
    step("lat_t1");
    chk("lat.busy_t1", 64'(s_busy[2:1]), 64'(2'b11));
    step("lat_t2");
    chk("lat.busy_t2", 64'(s_busy[2:1]), 64'(2'b00));

    // RAW inside the group, then the consumer issues from slot 0 via forwarding
    sl[0] = op(OP_ADD,3,0,0); sl[1] = op(OP_ADD,4,3,1);
    step("raw_grp");
    chk("raw.mask", 64'(s_mask), 64'(4'b0001));
    clear_slots();
    sl[0] = op(OP_ADD,4,3,1);
    step("raw_fwd");
    chk("raw.fwd_mask", 64'(s_mask), 64'(4'b0001));
    chk("raw.fwd_busy3", 64'(s_busy[3]), 64'(1));
    clear_slots();
    step("idle");

`ifndef ISSUE_SB_LOAD_WB_EN
    // load-use one cycle behind a bubble: exactly one stall cycle
    sl[0] = op(OP_LW,5,0,0);
    step("lu_load");
    clear_slots();
    step("lu_bubble");
    sl[0] = op(OP_ADD,6,5,0);
    step("lu_stall");
    chk("lu.stall_if", 64'(s_stall), 64'(1));
    chk("lu.stall_mask", 64'(s_mask), 64'(0));
    base = s_cnt;
    step("lu_go");
    chk("lu.go_mask", 64'(s_mask), 64'(4'b0001));
    chk("lu.stall_cnt", 64'(s_cnt), 64'(base + SCW'(1)));
    clear_slots();
`else
    // variable-latency load retired only by writeback
    sl[0] = op(OP_LW,9,0,0);
    step("wb_load");
    clear_slots();
    for (int c = 0; c < 10; c++) step("wb_hold");
    chk("wb.hold_busy9", 64'(s_busy[9]), 64'(1));
    ld_wb_valid = 1'b1; ld_wb_rd = 5'd9;
    step("wb_strobe");
    ld_wb_valid = 1'b0; ld_wb_rd = '0;
    step("wb_after");
    chk("wb.after_busy9", 64'(s_busy[9]), 64'(0));
    base = '0;
`endif

    // flush kills issue and clears an in-flight load
    sl[0] = op(OP_LW,7,0,0);
    step("fl_load");
    sl[0] = op(OP_ADD,8,0,0);
    flush = 1'b1;
    step("fl_cycle");
    chk("fl.mask", 64'(s_mask), 64'(0));
    flush = 1'b0;
    clear_slots();
    step("fl_after");
    chk("fl.busy", 64'(s_busy), 64'(0));

    // asynchronous reset in the middle of a countdown
    sl[0] = op(OP_LW,8,0,0); sl[1] = op(OP_ADD,9,0,0);
    step("ar_issue");
    #2 rst_n = 1'b0;
    #1;
    chk("ar.busy", 64'(busy_vec), 64'(0));
    chk("ar.ldpend", 64'(load_pending_vec), 64'(0));
    chk("ar.stall_cnt", 64'(stall_cycles), 64'(0));
    model_reset();
    clear_slots();
    put_slots();
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // random traffic with a narrow register window to provoke hazards
    for (int c = 0; c < 400; c++) begin
      for (int k = 0; k < W; k++) begin
        int kind;
        case ($urandom_range(0, 9))
          0, 1, 2, 3: kind = OP_ADD;
          4, 5:       kind = OP_LW;
          6:          kind = OP_SW;
          7:          kind = OP_BEQ;
          8:          kind = OP_LUI;
          default:    kind = OP_ECALL;
        endcase
        if ($urandom_range(0, 5) == 0) kind = OP_NOP;
        sl[k] = op(kind, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7));
      end
      flush = ($urandom_range(0, 15) == 0);
`ifdef ISSUE_SB_LOAD_WB_EN
      ld_wb_valid = ($urandom_range(0, 2) == 0);
      ld_wb_rd = 5'($urandom_range(0, 7));
`endif
      step("rnd");
    end
    flush = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
